cook_timer: RTL and testbench
=============================

COOK_TIMER -- requirements
Module: cook_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 4, meaning clk cycles per one-second tick (>=2).
REQ-002 SHALL have parameter WINDOW_S, default 10, meaning power duty window length in seconds.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  load or resume
- pause  in  1  suspend countdown
- cancel  in  1  abort to IDLE
- door_open  in  1  interlock
- in_first_s, in_second_s, in_first_m, in_second_m  in  4 each  BCD set time: s units, s tens, m units, m tens
- power_in  in  8  power percent
- first_s, second_s, first_m, second_m  out  4 each  remaining-time BCD digits
- magnetron_on  out  1  heating enable
- running  out  1  high in COOK
- done  out  1  high in DONE
- beep  out  1  completion tone
- input_err  out  1  one-cycle pulse on rejected start

Function
REQ-004 SHALL implement states IDLE, COOK, PAUSED, DONE.
REQ-005 SHALL apply same-cycle control priority: cancel > door_open > pause > start.
REQ-006 IDLE/DONE + start, door closed, valid nonzero time: SHALL latch digits and power next edge, enter COOK, clear prescaler.
REQ-007 Start with any digit >9, in_second_s >5, or all digits zero SHALL be ignored and pulse input_err one cycle.
REQ-008 Prescaler SHALL count 0..CLK_HZ-1 in COOK only; sec_tick on terminal count; first tick exactly CLK_HZ cycles after COOK entry.
REQ-009 Each sec_tick SHALL decrement time BCD with borrow: s units 0->9 borrows s tens; s tens 0->5 borrows m units; m units 0->9 borrows m tens.
REQ-010 A sec_tick at 00:01 SHALL yield 00:00 and enter DONE on the same edge.
REQ-011 COOK + pause or door_open SHALL enter PAUSED holding digits and prescaler; PAUSED + start with door closed SHALL resume COOK without prescaler reset.
REQ-012 Start in COOK SHALL be ignored; start while door_open SHALL be ignored in every state.
REQ-013 cancel in any state SHALL enter IDLE and zero all digits next edge.
REQ-014 Latched power SHALL clamp to 100; on_secs = power/10, integer floor.
REQ-015 Window second counter SHALL count 0..WINDOW_S-1 on sec_tick and reset on COOK entry from IDLE/DONE; magnetron_q high in COOK while counter < on_secs.
REQ-016 magnetron_on SHALL equal magnetron_q AND NOT door_open, combinational gate, so door opening kills heating the same cycle.
REQ-017 running = (state==COOK); done = (state==DONE).
REQ-018 DONE SHALL persist until cancel, door_open (to IDLE), or valid start.

Reset
REQ-019 reset low SHALL asynchronously force IDLE, all digits 0, prescaler/window 0, latched power 0, magnetron_on/running/done/beep/input_err 0.
REQ-020 Reset mid-COOK SHALL deassert magnetron_on immediately, not at the next edge.

Configuration
REQ-021 With COOK_BEEP_EN defined, beep SHALL go high on DONE entry and stay high for 3 sec_ticks (prescaler runs in DONE); cancel/door_open/start clear it.
REQ-022 Without COOK_BEEP_EN, beep SHALL be constant 0 and the prescaler SHALL stay idle in DONE.

Structure
REQ-023 Shared package cook_pkg SHALL hold the state enum, BCD digit typedef, POWER_MAX=100, BEEP_SECS=3.
REQ-024 Sub-module bcd_countdown SHALL implement the four-digit borrow decrement and zero detect; prescaler, window counter and FSM stay in cook_timer.

Verification (CLK_HZ=4)
REQ-025 Load 00:03, power 100, start -> DONE after exactly 12 cycles; magnetron_on high all 12; done high after.
REQ-026 Load 01:00 -> after 1 tick digits read 00:59; load 10:00 -> after 1 tick 09:59.
REQ-027 Power 30, load 00:20 -> magnetron_on high for seconds 0-2 and 10-12 of each window, low otherwise.
REQ-028 door_open at cycle 5 of COOK -> magnetron_on low same cycle, PAUSED; close, start -> resumes, total COOK cycles unchanged.
REQ-029 Start with in_second_s=6 or 00:00 -> stays IDLE, input_err one-cycle pulse.
REQ-030 COOK_BEEP_EN: 00:01 run -> beep high 12 cycles after DONE; cancel mid-beep -> beep low next edge, IDLE.

Source files
------------

// File: rtl/cook_pkg.sv
// Shared types and constants for the cook_timer block.
package cook_pkg;

    typedef enum logic [1:0] {S_IDLE, S_COOK, S_PAUSED, S_DONE} state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t m_tens;
        bcd_t m_units;
        bcd_t s_tens;
        bcd_t s_units;
    } time_t;

    localparam logic [7:0] POWER_MAX = 8'd100;
    localparam int         BEEP_SECS = 3;

    // A set time is usable only as real BCD with seconds below 60 and not 00:00.
    function automatic logic time_valid(time_t t);
        return (t.s_units <= 4'd9) && (t.s_tens <= 4'd5) &&
               (t.m_units <= 4'd9) && (t.m_tens <= 4'd9) && (t != '0);
    endfunction

endpackage

// File: rtl/bcd_countdown.sv
// Four-digit mm:ss BCD decrement with borrow, plus zero detect of the result.
module bcd_countdown
    import cook_pkg::*;
(
    input  time_t i_cur,
    output time_t o_nxt,
    output logic  o_nxt_zero
);

    always_comb begin
        o_nxt = i_cur;
        if (i_cur.s_units != 4'd0) begin
            o_nxt.s_units = i_cur.s_units - 4'd1;
        end else begin
            o_nxt.s_units = 4'd9;
            if (i_cur.s_tens != 4'd0) begin
                o_nxt.s_tens = i_cur.s_tens - 4'd1;
            end else begin
                o_nxt.s_tens = 4'd5;
                if (i_cur.m_units != 4'd0) begin
                    o_nxt.m_units = i_cur.m_units - 4'd1;
                end else begin
                    o_nxt.m_units = 4'd9;
                    o_nxt.m_tens  = i_cur.m_tens - 4'd1;
                end
            end
        end
    end

    assign o_nxt_zero = (o_nxt == '0);

endmodule

// File: rtl/cook_timer.sv
// Microwave cook timer: BCD countdown, power duty window, door interlock.
// Define COOK_BEEP_EN to enable the completion beep.
module cook_timer
    import cook_pkg::*;
#(
    parameter int CLK_HZ   = 4,
    parameter int WINDOW_S = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       cancel,
    input  logic       door_open,
    input  logic [3:0] in_first_s,
    input  logic [3:0] in_second_s,
    input  logic [3:0] in_first_m,
    input  logic [3:0] in_second_m,
    input  logic [7:0] power_in,
    output logic [3:0] first_s,
    output logic [3:0] second_s,
    output logic [3:0] first_m,
    output logic [3:0] second_m,
    output logic       magnetron_on,
    output logic       running,
    output logic       done,
    output logic       beep,
    output logic       input_err
);

    localparam int PW = $clog2(CLK_HZ);
    localparam int WW = (WINDOW_S > 1) ? $clog2(WINDOW_S) : 1;

    state_t          r_state, w_state_nxt;
    time_t           r_time, w_time_dec, w_time_in;
    logic            w_dec_zero;
    logic [PW-1:0]   r_presc;
    logic [WW-1:0]   r_win;
    logic [7:0]      r_power, w_on_secs;
    logic            r_err;
    logic            w_load, w_clr, w_err, w_run, w_at_tc, w_presc_en, w_mag_q;

    assign w_time_in = {in_second_m, in_first_m, in_second_s, in_first_s};
    assign w_at_tc   = (r_presc == PW'(CLK_HZ - 1));

    bcd_countdown u_cd (
        .i_cur      (r_time),
        .o_nxt      (w_time_dec),
        .o_nxt_zero (w_dec_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // w_run marks a COOK cycle with no control pending: only then time advances.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_clr       = 1'b0;
        w_err       = 1'b0;
        w_run       = 1'b0;
        if (cancel) begin
            w_state_nxt = S_IDLE;
            w_clr       = 1'b1;
        end else if (door_open) begin
            if (r_state == S_COOK)      w_state_nxt = S_PAUSED;
            else if (r_state == S_DONE) w_state_nxt = S_IDLE;
        end else if (pause) begin
            if (r_state == S_COOK) w_state_nxt = S_PAUSED;
        end else if (start && r_state != S_COOK) begin
            if (r_state == S_PAUSED) begin
                w_state_nxt = S_COOK;
            end else if (time_valid(w_time_in)) begin
                w_state_nxt = S_COOK;
                w_load      = 1'b1;
            end else begin
                w_err = 1'b1;
            end
        end else if (r_state == S_COOK) begin
            w_run = 1'b1;
            if (w_at_tc && w_dec_zero) w_state_nxt = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_time  <= '0;
            r_power <= '0;
            r_win   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_err;
            if (w_clr)                r_time <= '0;
            else if (w_load)          r_time <= w_time_in;
            else if (w_run && w_at_tc) r_time <= w_time_dec;
            if (w_load) r_power <= (power_in > POWER_MAX) ? POWER_MAX : power_in;
            if (w_load)                r_win <= '0;
            else if (w_run && w_at_tc) r_win <= (r_win == WW'(WINDOW_S - 1)) ? '0 : r_win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          r_presc <= '0;
        else if (w_load)     r_presc <= '0;
        else if (w_presc_en) r_presc <= w_at_tc ? '0 : r_presc + 1'b1;
    end

`ifdef COOK_BEEP_EN
    localparam int BW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
    logic          r_beep;
    logic [BW-1:0] r_beep_cnt;
    logic          w_beep_run, w_start_eval;

    assign w_start_eval = start && !cancel && !door_open && !pause;
    assign w_beep_run   = (r_state == S_DONE) && (w_state_nxt == S_DONE) && r_beep;
    assign w_presc_en   = w_run || w_beep_run;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beep     <= 1'b0;
            r_beep_cnt <= '0;
        end else if (r_state != S_DONE && w_state_nxt == S_DONE) begin
            r_beep     <= 1'b1;
            r_beep_cnt <= '0;
        end else if (r_state == S_DONE && (w_state_nxt != S_DONE || w_start_eval)) begin
            r_beep <= 1'b0;
        end else if (w_beep_run && w_at_tc) begin
            if (r_beep_cnt == BW'(BEEP_SECS - 1)) r_beep <= 1'b0;
            else                                  r_beep_cnt <= r_beep_cnt + 1'b1;
        end
    end

    assign beep = r_beep;
`else
    assign w_presc_en = w_run;
    assign beep       = 1'b0;
`endif

    assign w_on_secs = r_power / 8'd10;
    assign w_mag_q   = (r_state == S_COOK) && (32'(r_win) < 32'(w_on_secs));

    // Door gate is combinational so heating stops in the cycle the door opens.
    assign magnetron_on = w_mag_q & ~door_open;
    assign running      = (r_state == S_COOK);
    assign done         = (r_state == S_DONE);
    assign input_err    = r_err;
    assign first_s      = r_time.s_units;
    assign second_s     = r_time.s_tens;
    assign first_m      = r_time.m_units;
    assign second_m     = r_time.m_tens;

endmodule

// File: tb/tb_cook_timer.sv
// Randomized + directed bench for cook_timer against a seconds-based reference model.
module tb_cook_timer;

    localparam int CLK_HZ   = 4;
    localparam int WINDOW_S = 10;
    localparam int BEEP_CYC = 3 * CLK_HZ;

    logic       clk = 1'b0, reset = 1'b1;
    logic       start = 1'b0, pause = 1'b0, cancel = 1'b0, door_open = 1'b0;
    logic [3:0] in_first_s = '0, in_second_s = '0, in_first_m = '0, in_second_m = '0;
    logic [7:0] power_in = '0;
    logic [3:0] first_s, second_s, first_m, second_m;
    logic       magnetron_on, running, done, beep, input_err;

    int n_chk = 0, n_err = 0;

    typedef enum {M_IDLE, M_COOK, M_PAUSED, M_DONE} mst_t;
    mst_t m_st;
    int   m_secs, m_elapsed, m_phase, m_pow, m_beep_left;
    bit   m_err;

    cook_timer #(.CLK_HZ(CLK_HZ), .WINDOW_S(WINDOW_S)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .cancel(cancel),
        .door_open(door_open), .in_first_s(in_first_s), .in_second_s(in_second_s),
        .in_first_m(in_first_m), .in_second_m(in_second_m), .power_in(power_in),
        .first_s(first_s), .second_s(second_s), .first_m(first_m), .second_m(second_m),
        .magnetron_on(magnetron_on), .running(running), .done(done), .beep(beep),
        .input_err(input_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_secs = 0; m_elapsed = 0; m_phase = 0;
        m_pow = 0; m_beep_left = 0; m_err = 0;
    endtask

    function automatic int exp_mag();
        return int'(m_st == M_COOK && (m_elapsed % WINDOW_S) < m_pow / 10 && !door_open);
    endfunction

    // Remaining time is kept as plain seconds; one second passes every CLK_HZ free COOK cycles.
    task automatic model_step();
        mst_t prev;
        int   set_s;
        bit   ok;
        prev  = m_st;
        set_s = (int'(in_second_m) * 10 + int'(in_first_m)) * 60 + int'(in_second_s) * 10 + int'(in_first_s);
        ok    = in_first_s <= 9 && in_second_s <= 5 && in_first_m <= 9 && in_second_m <= 9 && set_s > 0;
        m_err = 0;
        if (cancel) begin
            m_st = M_IDLE; m_secs = 0;
        end else if (door_open) begin
            if (m_st == M_COOK)      m_st = M_PAUSED;
            else if (m_st == M_DONE) m_st = M_IDLE;
        end else if (pause) begin
            if (m_st == M_COOK) m_st = M_PAUSED;
        end else if (start && m_st != M_COOK) begin
            if (m_st == M_PAUSED) m_st = M_COOK;
            else if (ok) begin
                m_st = M_COOK; m_secs = set_s; m_phase = 0; m_elapsed = 0;
                m_pow = (int'(power_in) > 100) ? 100 : int'(power_in);
            end else m_err = 1;
        end else if (m_st == M_COOK) begin
            m_phase++;
            if (m_phase == CLK_HZ) begin
                m_phase = 0; m_secs--; m_elapsed++;
                if (m_secs == 0) m_st = M_DONE;
            end
        end
`ifdef COOK_BEEP_EN
        if (m_st == M_DONE && prev != M_DONE) m_beep_left = BEEP_CYC;
        else if (m_st != M_DONE || (start && !cancel && !door_open && !pause)) m_beep_left = 0;
        else if (m_beep_left > 0) m_beep_left--;
`endif
    endtask

    task automatic check_all();
        int mm, ss;
        mm = m_secs / 60;
        ss = m_secs % 60;
        chk("s_units", int'(first_s), ss % 10);
        chk("s_tens", int'(second_s), ss / 10);
        chk("m_units", int'(first_m), mm % 10);
        chk("m_tens", int'(second_m), mm / 10);
        chk("running", int'(running), int'(m_st == M_COOK));
        chk("done", int'(done), int'(m_st == M_DONE));
        chk("magnetron", int'(magnetron_on), exp_mag());
        chk("beep", int'(beep), int'(m_beep_left > 0));
        chk("input_err", int'(input_err), int'(m_err));
    endtask

    task automatic step();
        #2;
        chk("mag_comb", int'(magnetron_on), exp_mag());
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic load(input int mt, input int mu, input int st, input int su, input int p);
        in_second_m = 4'(mt); in_first_m = 4'(mu); in_second_s = 4'(st); in_first_s = 4'(su);
        power_in = 8'(p); start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1; step(); cancel = 1'b0;
    endtask

    initial begin
        int cnt, pre;
        model_reset();
        #1 reset = 1'b0;
        #2 check_all();
        @(posedge clk); #1 reset = 1'b1;
        step();

        // 00:03 at full power: exactly 12 COOK cycles, heating throughout
        load(0, 0, 0, 3, 100);
        cnt = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (running) cnt++;
            step();
        end
        chk("cook_cycles", cnt, 12);
        chk("done_after", int'(done), 1);
        repeat (16) step();

        load(0, 1, 0, 0, 50);
        repeat (CLK_HZ) step();
        chk("t0100_s", int'({second_s, first_s}), 8'h59);
        chk("t0100_m", int'({second_m, first_m}), 8'h00);
        do_cancel();
        chk("cancel_zero", int'({second_m, first_m, second_s, first_s}), 0);

        load(1, 0, 0, 0, 100);
        repeat (CLK_HZ) step();
        chk("t1000_s", int'({second_s, first_s}), 8'h59);
        chk("t1000_m", int'({second_m, first_m}), 8'h09);
        do_cancel();

        // 30% power: on for the first 3 seconds of each 10 s window
        load(0, 0, 2, 0, 30);
        for (int i = 0; i < 20 * CLK_HZ; i++) begin
            chk("pw30", int'(magnetron_on), int'(((i / CLK_HZ) % WINDOW_S) < 3));
            step();
        end
        chk("pw30_done", int'(done), 1);

        // door interruption keeps the total number of counting cycles
        load(0, 0, 0, 3, 100);
        pre = 0;
        repeat (5) begin
            if (running) pre++;
            step();
        end
        door_open = 1'b1;
        #1 chk("door_kill", int'(magnetron_on), 0);
        step();
        chk("door_paused", int'(running), 0);
        repeat (3) step();
        door_open = 1'b0; step();
        start = 1'b1; step(); start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (running) cnt++;
            step();
        end
        chk("door_total", pre + cnt, 12);
        do_cancel();

        // rejected starts
        load(0, 0, 6, 0, 50);
        chk("err_s6", int'(input_err), 1);
        chk("idle_s6", int'(running), 0);
        step();
        chk("err_pulse", int'(input_err), 0);
        load(0, 0, 0, 0, 50);
        chk("err_zero", int'(input_err), 1);
        load(0, 0, 0, 10, 50);
        chk("err_digit", int'(input_err), 1);
        step();

        // cancel while DONE (and beeping when enabled)
        load(0, 0, 0, 1, 100);
        repeat (CLK_HZ + 2) step();
        do_cancel();
        chk("beep_cancel", int'(beep), 0);
        chk("cancel_idle", int'(done), 0);

        // reset in the middle of a cook drops heating at once
        load(0, 0, 0, 5, 100);
        repeat (3) step();
        #2 reset = 1'b0;
        #1;
        chk("rst_mag", int'(magnetron_on), 0);
        chk("rst_run", int'(running), 0);
        chk("rst_time", int'({second_m, first_m, second_s, first_s}), 0);
        model_reset();
        @(posedge clk); #1 reset = 1'b1;
        check_all();

        for (int i = 0; i < 3000; i++) begin
            cancel = ($urandom_range(99) < 1);
            pause  = ($urandom_range(99) < 3);
            start  = ($urandom_range(99) < 8);
            if ($urandom_range(99) < 3) door_open = ~door_open;
            if ($urandom_range(9) < 8) begin
                in_second_m = 4'd0;
                in_first_m  = 4'($urandom_range(1));
                in_second_s = 4'($urandom_range(5));
                in_first_s  = 4'($urandom_range(9));
            end else begin
                in_second_m = 4'($urandom_range(15));
                in_first_m  = 4'($urandom_range(15));
                in_second_s = 4'($urandom_range(15));
                in_first_s  = 4'($urandom_range(15));
            end
            power_in = 8'($urandom_range(255));
            step();
        end
        cancel = 1'b0; pause = 1'b0; start = 1'b0; door_open = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
